// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - mos6502 instruction-fetch sequencer
// Owns the PC, fetches opcode plus 0..2 operand bytes and issues one instruction per valid/ready transfer.
module fetch_seq #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          op_len,
  input  logic                pc_load,
  input  logic [ADDR_W-1:0]   pc_load_addr,
  input  logic                halt,
  output logic                ins_valid,
  input  logic                ins_ready,
  output logic [DATA_W-1:0]   ins_opcode,
  output logic [2*DATA_W-1:0] ins_operand,
  output logic [1:0]          ins_len,
  output logic [ADDR_W-1:0]   ins_pc,
  output logic [2:0]          state_o
);

  localparam int                LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_OP = 3'd1,
    WAIT_OP  = 3'd2,
    FETCH_LO = 3'd3,
    WAIT_LO  = 3'd4,
    FETCH_HI = 3'd5,
    WAIT_HI  = 3'd6,
    VALID    = 3'd7
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [LAT_W-1:0]  lat_cnt;
  logic              decide;
  logic [1:0]        opnd_cnt;
  logic [1:0]        eff_len;
  logic              waiting;
  logic              rd_done;

  // decide marks the extra WAIT_OP cycle in which the decoder's op_len is sampled
  assign eff_len  = (op_len == 2'd3) ? 2'd2 : op_len;
  assign waiting  = ((state == WAIT_OP) || (state == WAIT_LO) || (state == WAIT_HI)) && !decide;
  assign rd_done  = waiting && (lat_cnt == LAT_LAST);

  assign mem_addr  = pc;
  assign mem_rd    = (state == FETCH_OP) || (state == FETCH_LO) || (state == FETCH_HI);
  assign ins_valid = (state == VALID);
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (!halt) state_nx = FETCH_OP;
      FETCH_OP: state_nx = WAIT_OP;
      WAIT_OP:  if (decide) state_nx = (eff_len == 2'd0) ? VALID : FETCH_LO;
      FETCH_LO: state_nx = WAIT_LO;
      WAIT_LO:  if (rd_done) state_nx = (opnd_cnt == 2'd2) ? FETCH_HI : VALID;
      FETCH_HI: state_nx = WAIT_HI;
      WAIT_HI:  if (rd_done) state_nx = VALID;
      VALID:    if (ins_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (pc_load) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      lat_cnt     <= '0;
      decide      <= 1'b0;
      opnd_cnt    <= 2'd0;
      ins_opcode  <= '0;
      ins_operand <= '0;
      ins_len     <= 2'd0;
      ins_pc      <= RESET_PC;
    end else if (pc_load) begin
      pc      <= pc_load_addr;
      lat_cnt <= '0;
      decide  <= 1'b0;
    end else begin
      lat_cnt <= (waiting && !rd_done) ? lat_cnt + LAT_W'(1) : '0;
      if (rd_done) pc <= pc + ADDR_W'(1);
      if (rd_done && (state == WAIT_OP)) begin
        ins_opcode  <= mem_rdata;
        ins_pc      <= pc;
        ins_operand <= '0;
        decide      <= 1'b1;
      end
      if (decide) begin
        decide   <= 1'b0;
        opnd_cnt <= eff_len;
        ins_len  <= eff_len + 2'd1;
      end
      if (rd_done && (state == WAIT_LO)) ins_operand[DATA_W-1:0]        <= mem_rdata;
      if (rd_done && (state == WAIT_HI)) ins_operand[2*DATA_W-1:DATA_W] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed and randomized bench for fetch_seq
// Two instances: a (MEM_LAT=1) and b (MEM_LAT=3), sharing one byte memory and opcode-length table.
module tb_fetch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] mem     [0:65535];
  logic [1:0] dec_tab [0:255];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] a_mem_addr, a_pc_load_addr, a_ins_operand, a_ins_pc;
  logic        a_mem_rd, a_pc_load, a_halt, a_ins_valid, a_ins_ready;
  logic [7:0]  a_mem_rdata, a_ins_opcode;
  logic [1:0]  a_op_len, a_ins_len;
  logic [2:0]  a_state;
  logic [15:0] b_mem_addr, b_pc_load_addr, b_ins_operand, b_ins_pc;
  logic        b_mem_rd, b_pc_load, b_halt, b_ins_valid, b_ins_ready;
  logic [7:0]  b_mem_rdata, b_ins_opcode;
  logic [1:0]  b_op_len, b_ins_len;
  logic [2:0]  b_state;
  logic [62:0] a_outs, b_outs;

  assign a_op_len = dec_tab[a_ins_opcode];
  assign b_op_len = dec_tab[b_ins_opcode];
  assign a_outs = {a_mem_addr, a_mem_rd, a_ins_valid, a_ins_opcode, a_ins_operand, a_ins_len, a_ins_pc, a_state};
  assign b_outs = {b_mem_addr, b_mem_rd, b_ins_valid, b_ins_opcode, b_ins_operand, b_ins_len, b_ins_pc, b_state};

  fetch_seq #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(1), .RESET_PC(16'h0000)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_rdata(a_mem_rdata),
    .op_len(a_op_len), .pc_load(a_pc_load), .pc_load_addr(a_pc_load_addr), .halt(a_halt),
    .ins_valid(a_ins_valid), .ins_ready(a_ins_ready), .ins_opcode(a_ins_opcode),
    .ins_operand(a_ins_operand), .ins_len(a_ins_len), .ins_pc(a_ins_pc), .state_o(a_state));

  fetch_seq #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(3), .RESET_PC(16'h0000)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_rdata(b_mem_rdata),
    .op_len(b_op_len), .pc_load(b_pc_load), .pc_load_addr(b_pc_load_addr), .halt(b_halt),
    .ins_valid(b_ins_valid), .ins_ready(b_ins_ready), .ins_opcode(b_ins_opcode),
    .ins_operand(b_ins_operand), .ins_len(b_ins_len), .ins_pc(b_ins_pc), .state_o(b_state));

  // Memory models: data valid exactly LAT cycles after the read strobe, garbage otherwise.
  int         a_cnt = 0, b_cnt = 0;
  logic [7:0] a_dat, b_dat;
  always @(posedge clk) begin
    if (a_mem_rd) begin a_dat = mem[a_mem_addr]; a_cnt = 1; end
    if (a_cnt == 1) begin a_mem_rdata <= a_dat; a_cnt = 0; end
    else begin a_mem_rdata <= 8'($urandom); if (a_cnt > 1) a_cnt--; end
  end
  always @(posedge clk) begin
    if (b_mem_rd) begin b_dat = mem[b_mem_addr]; b_cnt = 3; end
    if (b_cnt == 1) begin b_mem_rdata <= b_dat; b_cnt = 0; end
    else begin b_mem_rdata <= 8'($urandom); if (b_cnt > 1) b_cnt--; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input bit sel, input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (((sel ? b_state : a_state) !== s) && (n < budget)) begin @(negedge clk); n++; end
    chk({tag, "_reach"}, 64'((sel ? b_state : a_state) === s), 64'd1);
  endtask

  // Redirect an idle, halted instance and let exactly one fetch begin; returns in FETCH_OP.
  task automatic start(input bit sel, input logic [15:0] addr);
    @(negedge clk);
    if (sel) begin b_pc_load = 1'b1; b_pc_load_addr = addr; end
    else     begin a_pc_load = 1'b1; a_pc_load_addr = addr; end
    @(negedge clk);
    if (sel) begin b_pc_load = 1'b0; b_halt = 1'b0; end
    else     begin a_pc_load = 1'b0; a_halt = 1'b0; end
    @(negedge clk);
    if (sel) b_halt = 1'b1; else a_halt = 1'b1;
  endtask

  initial begin
    int          t0, bad, xfers;
    int          rd_cyc[$];
    logic [15:0] rd_adr[$];
    logic [15:0] mpc;
    logic [62:0] snap;
    logic        hold;
    logic [7:0]  op;
    logic [1:0]  n;
    logic [41:0] exp_ins;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) dec_tab[i] = 2'($urandom_range(0, 3));
    mem[16'h0000] = 8'hA9; mem[16'h0001] = 8'h05; dec_tab[8'hA9] = 2'd1;
    mem[16'h0010] = 8'h4C; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12; dec_tab[8'h4C] = 2'd2;
    mem[16'hFFFF] = 8'h4C; mem[16'h8000] = 8'hEA; dec_tab[8'hEA] = 2'd0;

    rst_n = 1'b0;
    a_halt = 1'b0; a_ins_ready = 1'b1; a_pc_load = 1'b0; a_pc_load_addr = 16'h0;
    b_halt = 1'b1; b_ins_ready = 1'b0; b_pc_load = 1'b0; b_pc_load_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk("a_reset_outputs", 64'(a_outs), 64'd0);
    chk("b_reset_outputs", 64'(b_outs), 64'd0);

    // 2-byte instruction straight out of reset
    rst_n = 1'b1;
    wait_state(1'b0, 3'd7, 20, "t1_valid");
    a_halt = 1'b1;
    chk("t1_opcode", 64'(a_ins_opcode), 64'hA9);
    chk("t1_operand", 64'(a_ins_operand), 64'h0005);
    chk("t1_len", 64'(a_ins_len), 64'd2);
    chk("t1_ins_pc", 64'(a_ins_pc), 64'h0000);
    @(negedge clk);
    chk("t1_valid_drop", 64'(a_ins_valid), 64'd0);
    chk("t1_next_addr", 64'(a_mem_addr), 64'h0002);

    // b has been halted since reset
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ((b_state !== 3'd0) || (b_mem_rd !== 1'b0)) bad++;
    end
    chk("b_halt_idle", 64'(bad), 64'd0);

    // 3-byte instruction with read latency 3
    start(1'b1, 16'h0010);
    t0 = cyc;
    for (int i = 0; i < 60; i++) begin
      if (b_mem_rd) begin rd_cyc.push_back(cyc); rd_adr.push_back(b_mem_addr); end
      if (b_state == 3'd7) break;
      @(negedge clk);
    end
    chk("t2_valid", 64'(b_ins_valid), 64'd1);
    chk("t2_latency", 64'(cyc - t0), 64'd13);
    chk("t2_rd_count", 64'(rd_cyc.size()), 64'd3);
    if (rd_cyc.size() == 3) begin
      chk("t2_rd_addrs", 64'({rd_adr[0], rd_adr[1], rd_adr[2]}), 64'h0010_0011_0012);
      chk("t2_op_to_lo", 64'(rd_cyc[1] - rd_cyc[0]), 64'd5);
      chk("t2_lo_to_hi", 64'(rd_cyc[2] - rd_cyc[1]), 64'd4);
    end
    chk("t2_ins", 64'({b_ins_opcode, b_ins_operand, b_ins_len, b_ins_pc}), 64'({8'h4C, 16'h1234, 2'd3, 16'h0010}));
    b_ins_ready = 1'b1;
    @(negedge clk);
    chk("t2_valid_drop", 64'(b_ins_valid), 64'd0);
    chk("t2_pc_after", 64'(b_mem_addr), 64'h0013);

    // consumer stalls for 10 cycles in VALID
    a_ins_ready = 1'b0;
    start(1'b0, 16'h0010);
    t0 = cyc;
    wait_state(1'b0, 3'd7, 20, "t3_valid");
    chk("t3_latency", 64'(cyc - t0), 64'd7);
    chk("t3_ins", 64'({a_ins_opcode, a_ins_operand, a_ins_len, a_ins_pc}), 64'({8'h4C, 16'h1234, 2'd3, 16'h0010}));
    snap = a_outs;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ((a_outs !== snap) || (a_mem_rd !== 1'b0)) bad++;
    end
    chk("t3_stall_stable", 64'(bad), 64'd0);
    a_ins_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", 64'(a_ins_valid), 64'd0);
    chk("t3_idle_after", 64'(a_state), 64'd0);

    // redirect during WAIT_LO discards the in-flight instruction
    start(1'b0, 16'h0010);
    wait_state(1'b0, 3'd4, 20, "t4_wait_lo");
    a_pc_load = 1'b1; a_pc_load_addr = 16'h8000; a_halt = 1'b0;
    @(negedge clk);
    a_pc_load = 1'b0;
    chk("t4_valid_cancel", 64'(a_ins_valid), 64'd0);
    chk("t4_redirect_pc", 64'(a_mem_addr), 64'h8000);
    @(negedge clk);
    a_halt = 1'b1;
    chk("t4_fetch", 64'({a_mem_rd, a_mem_addr}), 64'({1'b1, 16'h8000}));
    wait_state(1'b0, 3'd7, 20, "t4_valid");
    chk("t4_ins", 64'({a_ins_opcode, a_ins_operand, a_ins_len, a_ins_pc}), 64'({8'hEA, 16'h0000, 2'd1, 16'h8000}));
    @(negedge clk);

    // opcode at the top of memory, operands wrap to 0000/0001
    start(1'b0, 16'hFFFF);
    wait_state(1'b0, 3'd7, 20, "t5_valid");
    chk("t5_ins", 64'({a_ins_opcode, a_ins_operand, a_ins_len, a_ins_pc}), 64'({8'h4C, 16'h05A9, 2'd3, 16'hFFFF}));
    @(negedge clk);
    chk("t5_pc_after", 64'(a_mem_addr), 64'h0002);

    // randomized traffic against a transaction-level model
    @(negedge clk);
    mpc = 16'($urandom);
    a_pc_load = 1'b1; a_pc_load_addr = mpc;
    hold = 1'b0; bad = 0; xfers = 0; snap = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hold && ((a_ins_valid !== 1'b1) || (a_outs !== snap))) bad++;
      a_ins_ready    = ($urandom_range(0, 9) < 7);
      a_halt         = ($urandom_range(0, 9) < 2);
      a_pc_load      = ($urandom_range(0, 49) == 0);
      a_pc_load_addr = 16'($urandom);
      if (a_pc_load) begin
        mpc = a_pc_load_addr;
      end else if (a_ins_valid && a_ins_ready) begin
        op = mem[mpc];
        n  = (dec_tab[op] == 2'd3) ? 2'd2 : dec_tab[op];
        exp_ins = {op,
                   (n == 2'd2) ? mem[16'(mpc + 16'd2)] : 8'h00,
                   (n != 2'd0) ? mem[16'(mpc + 16'd1)] : 8'h00,
                   2'(n + 2'd1), mpc};
        chk("rnd_xfer", 64'({a_ins_opcode, a_ins_operand, a_ins_len, a_ins_pc}), 64'(exp_ins));
        mpc = 16'(mpc + 16'(n) + 16'd1);
        xfers++;
      end
      hold = a_ins_valid && !a_ins_ready && !a_pc_load;
      snap = a_outs;
    end
    a_pc_load = 1'b0; a_halt = 1'b1;
    chk("rnd_stall_stable", 64'(bad), 64'd0);
    chk("rnd_enough_xfers", 64'(xfers > 50), 64'd1);

    // asynchronous reset in the middle of WAIT_HI
    b_ins_ready = 1'b0;
    start(1'b1, 16'h0010);
    wait_state(1'b1, 3'd6, 40, "t6_wait_hi");
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", 64'(b_outs), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
